// File: rtl/level_alarm_monitor.sv
// Level alarm monitor: synchronises a thermometer-coded sensor bus, converts it to a level count,
// tracks the peak and trough levels, and runs a debounced alarm FSM with hysteresis.
module level_alarm_monitor #(
  parameter int N_SENSORS  = 8,
  parameter int HOLD_TICKS = 3,
  parameter int HYST       = 1,
  localparam int LW        = $clog2(N_SENSORS + 1)
) (
  input  logic                 clk_100MHz,
  input  logic                 reset,
  input  logic                 tick_1kHz,
  input  logic [N_SENSORS-1:0] sensors_input,
  input  logic [LW-1:0]        high_threshold,
  input  logic [LW-1:0]        low_threshold,
  input  logic                 clear_peaks,
  output logic [LW-1:0]        level,
  output logic [2:0]           state,
  output logic                 high_alarm,
  output logic                 low_alarm,
  output logic                 fault,
  output logic                 cfg_error,
  output logic                 event_pulse,
  output logic [LW-1:0]        max_level,
  output logic [LW-1:0]        min_level
);

  localparam int CW = $clog2(HOLD_TICKS + 1);
  localparam int XW = LW + 1;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_NORMAL = 3'd1,
    ST_HIGH   = 3'd2,
    ST_LOW    = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  logic [N_SENSORS-1:0] sync1_q, sync2_q;
  logic [LW-1:0]        level_q, max_q, min_q;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
  state_e               state_q, state_d, prev_q, prev_d, target;
  logic                 event_q, high_q, low_q, fault_q;

  logic [N_SENSORS-1:0] s_plus;
  logic                 valid;
  logic [LW-1:0]        k;
  logic [XW-1:0]        k_ext, hi_ext, hi_exit, lo_sum, lo_exit;

  function automatic state_e classify(input logic [LW-1:0] lv, input logic [LW-1:0] hi,
                                      input logic [LW-1:0] lo);
    if (lv >= hi)      return ST_HIGH;
    else if (lv <= lo) return ST_LOW;
    else               return ST_NORMAL;
  endfunction

  assign cfg_error = (low_threshold >= high_threshold);

  // A thermometer code plus one is a power of two (or wraps to zero), so it shares no set bits.
  always_comb begin
    s_plus = sync2_q + N_SENSORS'(1);
    valid  = ((sync2_q & s_plus) == '0);
    k      = '0;
    for (int i = 0; i < N_SENSORS; i++) k = k + LW'(sync2_q[i]);
  end

  always_comb begin
    k_ext   = {1'b0, k};
    hi_ext  = {1'b0, high_threshold};
    hi_exit = (hi_ext >= XW'(HYST)) ? hi_ext - XW'(HYST) : '0;
    lo_sum  = {1'b0, low_threshold} + XW'(HYST);
    lo_exit = (lo_sum > XW'(N_SENSORS)) ? XW'(N_SENSORS) : lo_sum;
  end

  // Target classification; an illegal threshold pair freezes the FSM except for fault detection.
  always_comb begin
    target = state_q;
    if (!valid) begin
      target = ST_FAULT;
    end else if (!cfg_error) begin
      case (state_q)
        ST_HIGH: if (k_ext < hi_exit)
                   target = (k <= low_threshold) ? ST_LOW : ST_NORMAL;
        ST_LOW:  if (k_ext > lo_exit)
                   target = (k >= high_threshold) ? ST_HIGH : ST_NORMAL;
        default: target = classify(k, high_threshold, low_threshold);
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    cnt_inc = (target == prev_q) ? cnt_q + CW'(1) : CW'(1);
    if (tick_1kHz) begin
      prev_d = target;
      if (target == state_q) begin
        cnt_d = '0;
      end else if (state_q == ST_INIT || cnt_inc == CW'(HOLD_TICKS)) begin
        state_d = target;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      max_q   <= '0;
      min_q   <= '1;
      cnt_q   <= '0;
      state_q <= ST_INIT;
      prev_q  <= ST_INIT;
      event_q <= 1'b0;
      high_q  <= 1'b0;
      low_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      sync1_q <= sensors_input;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      event_q <= (state_d != state_q);
      high_q  <= (state_d == ST_HIGH);
      low_q   <= (state_d == ST_LOW);
      fault_q <= (state_d == ST_FAULT);
      if (tick_1kHz && valid) level_q <= k;
      // A coincident clear takes the fresh sample rather than the stale level.
      if (clear_peaks) begin
        max_q <= (tick_1kHz && valid) ? k : level_q;
        min_q <= (tick_1kHz && valid) ? k : level_q;
      end else if (tick_1kHz && valid) begin
        if (k > max_q) max_q <= k;
        if (k < min_q) min_q <= k;
      end
    end
  end

  assign level       = level_q;
  assign state       = state_q;
  assign high_alarm  = high_q;
  assign low_alarm   = low_q;
  assign fault       = fault_q;
  assign event_pulse = event_q;
  assign max_level   = max_q;
  assign min_level   = min_q;

endmodule
